// File: rtl/adder_tree_pipe_if.sv
// Handshake bundle for adder_tree_pipe: operand vector in, registered sum and overflow flag out.
// master drives operands and consumes results; slave is the adder tree itself.
interface adder_tree_pipe_if #(
  parameter int unsigned N_INPUTS = 5,
  parameter int unsigned WIDTH    = 8
);
  logic                      in_valid;
  logic                      in_ready;
  logic [N_INPUTS*WIDTH-1:0] in_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [WIDTH-1:0]          result;
  logic                      ovf;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, result, ovf
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, result, ovf
  );
endinterface

// File: rtl/adder_tree_pipe.sv
// Pipelined N-input fixed-point adder tree, one register stage per tree level, valid/ready.
// Define ADDER_TREE_SAT_EN to clamp every adder on overflow instead of wrapping.
module adder_tree_pipe #(
  parameter int unsigned SIGN         = 1,
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned FP_POSITIONS = 4,
  parameter int unsigned N_INPUTS     = 5
) (
  input logic              clk,
  input logic              rst,
  adder_tree_pipe_if.slave bus
);

  // Number of elements held at tree level k (level 0 is the raw operand vector).
  function automatic int unsigned lvl_cnt(input int unsigned k);
    int unsigned m;
    m = N_INPUTS;
    for (int unsigned l = 0; l < k; l++) m = (m + 1) / 2;
    return m;
  endfunction

  localparam int unsigned LEVELS = (N_INPUTS <= 1) ? 1 : $clog2(N_INPUTS);

  if (N_INPUTS < 1 || N_INPUTS > 64) begin : g_bad_n
    $error("adder_tree_pipe: N_INPUTS must be 1..64");
  end
  if (FP_POSITIONS > WIDTH) begin : g_bad_fp
    $error("adder_tree_pipe: FP_POSITIONS exceeds WIDTH");
  end

  // Returns {ovf, sum}.
  function automatic logic [WIDTH:0] add2(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH:0]   full;
    logic [WIDTH-1:0] s;
    logic             o;
    full = {1'b0, a} + {1'b0, b};
    s    = full[WIDTH-1:0];
    if (SIGN != 0) o = (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
    else           o = full[WIDTH];
`ifdef ADDER_TREE_SAT_EN
    if (o) begin
      if (SIGN != 0) s = a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      else           s = '1;
    end
`endif
    return {o, s};
  endfunction

  logic              advance;
  logic [LEVELS-1:0] vld_d, vld_q;

  // Single global enable: the whole pipe moves or the whole pipe holds.
  assign advance = !vld_q[LEVELS-1] || bus.out_ready;

  always_comb begin
    vld_d = LEVELS'({vld_q, bus.in_valid});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          vld_q <= '0;
    else if (advance) vld_q <= vld_d;
  end

  for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
    localparam int unsigned MPrev = lvl_cnt(k - 1);
    for (genvar j = 0; j < lvl_cnt(k); j++) begin : g_node
      localparam bit Pair = (2 * j + 1) < MPrev;
      logic [WIDTH-1:0] a_w, sum_d, sum_q;
      logic             a_ovf, ovf_d, ovf_q;

      if (k == 1) begin : g_a
        assign a_w   = bus.in_data[2*j*WIDTH +: WIDTH];
        assign a_ovf = 1'b0;
      end else begin : g_a
        assign a_w   = g_lvl[k-1].g_node[2*j].sum_q;
        assign a_ovf = g_lvl[k-1].g_node[2*j].ovf_q;
      end

      if (Pair) begin : g_add
        logic [WIDTH-1:0] b_w;
        logic             b_ovf;
        logic [WIDTH:0]   r;
        if (k == 1) begin : g_b
          assign b_w   = bus.in_data[(2*j+1)*WIDTH +: WIDTH];
          assign b_ovf = 1'b0;
        end else begin : g_b
          assign b_w   = g_lvl[k-1].g_node[2*j+1].sum_q;
          assign b_ovf = g_lvl[k-1].g_node[2*j+1].ovf_q;
        end
        always_comb begin
          r     = add2(a_w, b_w);
          sum_d = r[WIDTH-1:0];
          ovf_d = r[WIDTH] | a_ovf | b_ovf;
        end
      end else begin : g_pass
        // Odd element out: registered unchanged, contributes no overflow of its own.
        always_comb begin
          sum_d = a_w;
          ovf_d = a_ovf;
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sum_q <= '0;
          ovf_q <= 1'b0;
        end else if (advance) begin
          sum_q <= sum_d;
          ovf_q <= ovf_d;
        end
      end
    end
  end

  assign bus.in_ready  = advance;
  assign bus.out_valid = vld_q[LEVELS-1];
  assign bus.result    = g_lvl[LEVELS].g_node[0].sum_q;
  assign bus.ovf       = g_lvl[LEVELS].g_node[0].ovf_q;

endmodule

// File: doc/adder_tree_pipe.md
Name: adder_tree_pipe

Overview:
- Parametrised, pipelined N-input fixed-point adder tree; successor to the fixed five-input single-register tree.
- Sums N_INPUTS operands of identical Q-format using one register stage per tree level.
- Adds a valid/ready handshake with backpressure and a per-result overflow flag.
- Sits between the MAC/neuron accumulation stage and the activation unit.

Parameters:
- SIGN, 1, 1 = two's-complement operands, 0 = unsigned.
- WIDTH, 8, operand and result width in bits.
- FP_POSITIONS, 4, fractional bits. All operands share this scale, so no alignment; carried for downstream consistency only.
- N_INPUTS, 5, number of operands, legal range 1..64.
- LEVELS, derived (localparam), max(1, ceil(log2(N_INPUTS))); equals pipeline latency.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  in_data holds a valid operand vector.
- in_ready  out  1  tree accepts in_data this cycle.
- in_data  in  N_INPUTS*WIDTH  operand i at [i*WIDTH +: WIDTH].
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- result  out  WIDTH  registered sum.
- ovf  out  1  an overflow occurred at any level for this result.

Behaviour:
- Reset (async, rst=1): all stage valid bits, result, and ovf cleared to 0. in_ready = 1 once rst deasserts (comb. from out_ready / last-stage valid). Reset mid-operation discards all in-flight vectors; no output after release until new inputs arrive.
- Tree structure:
  - Level k takes the M operands of level k-1 and pairs elements 2i and 2i+1.
  - For odd M, the last element passes through unchanged (registered, no overflow contribution).
  - Level 1 operates on in_data. Level LEVELS holds exactly one element, driven on result.
- Adder arithmetic (each pair, WIDTH bits, same scale):
  - Full-precision sum is WIDTH+1 bits.
  - Signed overflow: operand signs equal and sum sign differs.
  - Unsigned overflow: carry out.
  - Default: result wraps (low WIDTH bits). Saturation is covered under Optional Feature.
- ovf: OR of the overflow flags of every adder on the path, carried stage to stage alongside the data.
- N_INPUTS=1: single register stage, result = operand, ovf = 0.
- Pipeline control:
  - Global enable: advance = !out_valid || out_ready; in_ready = advance.
  - When advance=1, all stages shift together. Stage-1 valid <= in_valid; stage k valid <= stage k-1 valid.
  - When advance=0, all stages and outputs hold. Bubbles are not compressed.
- Handshake rules:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - result and ovf are stable while out_valid && !out_ready.
  - Simultaneous output accept and input accept in one cycle is legal: full throughput of one vector per cycle.
- Latency: LEVELS cycles from input transfer to out_valid, with no stalls.
- Ordering: strictly FIFO. No drop or duplication under any out_ready pattern.

Optional Feature:
- Macro: ADDER_TREE_SAT_EN.
- Defined: each adder clamps on overflow.
  - Signed: to 0x7F..F (positive overflow) or 0x80..0 (negative overflow).
  - Unsigned: to all-ones.
  - Clamping is per level, so intermediate sums saturate. ovf is still reported.
- Undefined: wrap-around as in Behaviour; ovf still reported.

Test Plan (WIDTH=8, FP_POSITIONS=4, N_INPUTS=5, LEVELS=3 unless noted):
1. Basic sum: five operands 0x10 (1.0), SIGN=1, out_ready=1 -> result=0x50 (5.0), ovf=0, out_valid exactly 3 cycles after accept.
2. Negative values: five operands 0xF0 (-1.0) -> result=0xB0 (-5.0), ovf=0. Mixed vector 0x18, 0xE8, 0x08, 0x00, 0xF8 -> 0x00.
3. Overflow: five operands 0x40, SIGN=1.
   - Wrap build -> result=0x40, ovf=1.
   - ADDER_TREE_SAT_EN build -> result=0x7F, ovf=1.
   - SIGN=0, five 0x40: wrap -> 0x40, ovf=1; SAT -> 0xFF.
4. Backpressure: stream vectors with sums 0x10, 0x20, 0x30, 0x40 back-to-back; out_ready=0 from cycle 2 for 5 cycles.
   - in_ready drops while out_valid=1.
   - result holds at 0x10 while stalled.
   - After release, outputs appear in order 0x10, 0x20, 0x30, 0x40, one per cycle.
5. Full throughput with random bubbles: 100 random vectors, random in_valid and out_ready -> each output matches the wrap-model sum and ovf for its vector, in order, no loss.
6. Reset mid-flight: assert rst while 2 vectors are in flight -> out_valid=0, result=0x00, ovf=0 immediately (async). After release no stale output; a new vector of five 0x10 yields 0x50 after 3 cycles. Also run N_INPUTS=1 (latency 1, passthrough) and N_INPUTS=8 (LEVELS=3).
